mux4_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-1 mux output channel among four requesters. It owns the mux select lines S1/S0 and issues a one-hot grant with a valid flag. Grant length is bounded by a burst limit, and a one-cycle guard gap separates successive grants. It sits directly in front of `mux4_to_1`: S1/S0 drive the mux select inputs, and requester *i* drives mux data input IN*i*.

---
 rtl/mux4_arbiter.sv | 128 ++++++++++++
 tb/tb_mux4_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter that owns the select lines of a
// 4-to-1 mux. Requester i drives mux data input i. A grant is held for
// at most HOLD_MAX cycles and is followed by a one-cycle guard gap. The
// requester that has just released becomes the lowest priority.
//
// Ports:
//   clk_i    : sole clock, rising edge
//   rst_i    : asynchronous active-high reset
//   req_i    : request vector, req_i[i] held high while requester i wants the channel
//   gnt_o    : registered one-hot grant, all zero when no grant is active
//   s1_o     : registered mux select MSB ({s1_o,s0_o} = granted index)
//   s0_o     : registered mux select LSB
//   valid_o  : high exactly when gnt_o is non-zero
//
// State | meaning
// IDLE  | no grant, no requests seen at the last edge
// GRANT | gnt_o/valid_o asserted for index sel_q
// GAP   | one-cycle guard after a release; arbitrates at its closing edge
module mux4_arbiter #(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] req_i,
   output logic [3:0] gnt_o,
   output logic       s1_o,
   output logic       s0_o,
   output logic       valid_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       gnt_q, gnt_d;
   logic             valid_q, valid_d;

   logic             win_found;
   logic [1:0]       win_idx;

   // Scan starts one past base and wraps; the loop runs from the farthest
   // offset down so the nearest set bit is the last one written.
   function automatic logic [2:0] arbitrate(input logic [3:0] req, input logic [1:0] base);
      logic [1:0] idx;
      arbitrate = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = base + 2'(k);
         if (req[idx]) arbitrate = {1'b1, idx};
      end
   endfunction

   always_comb begin
      {win_found, win_idx} = arbitrate(req_i, last_q);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      unique case (state_q)
         ST_GRANT: begin
            if (!req_i[sel_q] || cnt_q == HOLD_C) begin
               state_d = ST_GAP;
               gnt_d   = 4'b0000;
               valid_d = 1'b0;
               last_d  = sel_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_IDLE, ST_GAP: begin
            if (win_found) begin
               state_d = ST_GRANT;
               sel_d   = win_idx;
               gnt_d   = 4'b0001 << win_idx;
               valid_d = 1'b1;
               cnt_d   = CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
               gnt_d   = 4'b0000;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
         gnt_q   <= 4'b0000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign valid_o = valid_q;
   assign s1_o    = sel_q[1];
   assign s0_o    = sel_q[0];

endmodule

// File: tb/tb_mux4_arbiter.sv
module tb_mux4_arbiter;

   localparam int HOLD = 4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       s1, s0, valid;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the channel and for how long.
   int m_owner;  // -1 when nobody holds a grant
   int m_hold;
   int m_last;
   int m_sel;

   mux4_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .gnt_o   (gnt),
      .s1_o    (s1),
      .s0_o    (s0),
      .valid_o (valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_last  = 3;
      m_sel   = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      int w;
      if (m_owner >= 0) begin
         if (!r[m_owner] || m_hold == HOLD) begin
            m_last  = m_owner;
            m_owner = -1;
         end else begin
            m_hold++;
         end
      end else begin
         w = -1;
         for (int i = 1; i <= 4; i++)
            if (w < 0 && r[(m_last + i) % 4]) w = (m_last + i) % 4;
         if (w >= 0) begin
            m_owner = w;
            m_hold  = 1;
            m_sel   = w;
         end
      end
   endtask

   task automatic expect4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      expect4({tag, "_gnt"}, gnt, eg);
      expect4({tag, "_valid"}, {3'b000, valid}, {3'b000, (m_owner >= 0)});
      expect4({tag, "_sel"}, {2'b00, s1, s0}, 4'(m_sel));
   endtask

   // One clock: model follows the edge, outputs checked at the falling edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step(req);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      expect4("rst_gnt", gnt, 4'b0000);
      expect4("rst_valid", {3'b000, valid}, 4'b0000);
      expect4("rst_sel", {2'b00, s1, s0}, 4'b0000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int run;
      rst = 1'b0;
      req = 4'b0000;
      model_reset();
      #1 rst = 1'b1;

      // Reset held with clock running and all requesting.
      req = 4'b1111;
      repeat (2) @(negedge clk);
      expect4("rst_hold_gnt", gnt, 4'b0000);
      expect4("rst_hold_valid", {3'b000, valid}, 4'b0000);
      expect4("rst_hold_sel", {2'b00, s1, s0}, 4'b0000);
      rst = 1'b0;

      // Full load: rotation 0,1,2,3,0 with 4-cycle bursts and 1-cycle gaps.
      cycle("full");
      expect4("first_grant", gnt, 4'b0001);
      repeat (21) cycle("full");

      // Single requester from idle.
      req = 4'b0000;
      repeat (6) cycle("drain");
      req = 4'b0100;
      cycle("single");
      expect4("single_gnt", gnt, 4'b0100);
      expect4("single_sel", {2'b00, s1, s0}, 4'b0010);
      repeat (10) cycle("single");

      // Early release.
      req = 4'b0000;
      pulse_reset();
      req = 4'b1010;
      cycle("early");
      expect4("early_first", gnt, 4'b0010);
      cycle("early");
      req = 4'b1000;
      cycle("early");
      expect4("early_release", gnt, 4'b0000);
      cycle("early");
      expect4("early_next", gnt, 4'b1000);
      expect4("early_next_sel", {2'b00, s1, s0}, 4'b0011);
      repeat (5) cycle("early");

      // Rotation fairness: index 1 releases with 1 and 0 both requesting.
      req = 4'b0000;
      pulse_reset();
      req = 4'b0010;
      cycle("rot");
      req = 4'b0011;
      repeat (3) cycle("rot");
      cycle("rot");
      expect4("rot_gap", gnt, 4'b0000);
      cycle("rot");
      expect4("rot_winner", gnt, 4'b0001);

      // Async reset in the middle of a grant, between clock edges.
      req = 4'b0000;
      pulse_reset();
      req = 4'b0100;
      cycle("mid");
      cycle("mid");
      #2 rst = 1'b1;
      #1;
      expect4("mid_rst_gnt", gnt, 4'b0000);
      expect4("mid_rst_valid", {3'b000, valid}, 4'b0000);
      expect4("mid_rst_sel", {2'b00, s1, s0}, 4'b0000);
      model_reset();
      #1 rst = 1'b0;
      cycle("mid");
      expect4("mid_regrant", gnt, 4'b0100);
      run = 1;
      for (int i = 0; i < 10 && valid; i++) begin
         cycle("mid");
         if (valid) run++;
      end
      expect4("mid_burst_len", 4'(run), 4'(HOLD));

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
